// File: rtl/dmem_access_unit_if.sv
// ---------------------------------------------------------------------------
// dmem_access_unit_if
// Bus-side signal bundle between the M-stage data-memory access unit and the
// data-memory slave.
//   o_busReq    request, held high for the whole outstanding access
//   o_busWe     1 = write, 0 = read
//   o_busAddr   word-aligned byte address
//   o_busBe     byte lane enables
//   o_busWdata  lane-replicated store data
//   i_busAck    slave completion (only meaningful while o_busReq=1)
//   i_busRdata  read word, sampled on the ack cycle
// Modports: master = access unit side, slave = memory side.
// ---------------------------------------------------------------------------
interface dmem_access_unit_if;
  logic        o_busReq;
  logic        o_busWe;
  logic [31:0] o_busAddr;
  logic [3:0]  o_busBe;
  logic [31:0] o_busWdata;
  logic        i_busAck;
  logic [31:0] i_busRdata;

  modport master (
    output o_busReq, o_busWe, o_busAddr, o_busBe, o_busWdata,
    input  i_busAck, i_busRdata
  );

  modport slave (
    input  o_busReq, o_busWe, o_busAddr, o_busBe, o_busWdata,
    output i_busAck, i_busRdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// ---------------------------------------------------------------------------
// dmem_access_unit
// M-stage data-memory access unit. Turns a load/store request from the
// pipeline into a registered bus transaction, stalls the pipeline while the
// access is outstanding, and returns load data right-aligned to bit 0.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   i_memRead         load request
//   i_memWrite        store request (wins if both are set)
//   i_memSize         00 byte, 01 half, 10/11 word
//   i_addr            byte address
//   i_writeData       store data, LSB-aligned
//   o_stall           freezes the upstream pipeline
//   o_readData        load data shifted to bit 0, upper bits zero
//   o_misaligned      one-cycle flag: access rejected as misaligned
//   o_busErr          one-cycle flag: access aborted on timeout
//   bus               master side of the memory bus
// Parameter:
//   TIMEOUT           REQ cycles without ack before abort (2..255)
// ---------------------------------------------------------------------------
module dmem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_memRead,
  input  logic                       i_memWrite,
  input  logic [1:0]                 i_memSize,
  input  logic [31:0]                i_addr,
  input  logic [31:0]                i_writeData,
  output logic                       o_stall,
  output logic [31:0]                o_readData,
  output logic                       o_misaligned,
  output logic                       o_busErr,
  dmem_access_unit_if.master         bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        access;
  logic        misal;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] rd_shifted;
  logic [31:0] rd_aligned;
  logic        stall_c;
  logic        misal_c;
  logic        err_c;

  // Request decode, valid only while IDLE.
  always_comb begin
    access     = i_memRead | i_memWrite;
    misal      = 1'b0;
    be_calc    = 4'b1111;
    wdata_calc = i_writeData;
    case (i_memSize)
      2'b00: begin
        be_calc    = 4'b0001 << i_addr[1:0];
        wdata_calc = {4{i_writeData[7:0]}};
      end
      2'b01: begin
        misal      = i_addr[0];
        be_calc    = 4'b0011 << {i_addr[1], 1'b0};
        wdata_calc = {2{i_writeData[15:0]}};
      end
      default: begin
        misal      = (i_addr[1:0] != 2'b00);
        be_calc    = 4'b1111;
        wdata_calc = i_writeData;
      end
    endcase
  end

  // Load data alignment uses the offset/size latched at issue, since the
  // pipeline inputs are not guaranteed stable once the bus cycle is running.
  always_comb begin
    rd_shifted = bus.i_busRdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   rd_aligned = {24'd0, rd_shifted[7:0]};
      2'b01:   rd_aligned = {16'd0, rd_shifted[15:0]};
      default: rd_aligned = rd_shifted;
    endcase
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    off_d   = off_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    stall_c = 1'b0;
    misal_c = 1'b0;
    err_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (access) begin
          if (misal) begin
            misal_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            state_d = REQ;
            cnt_d   = 8'd0;
            req_d   = 1'b1;
            we_d    = i_memWrite;
            addr_d  = {i_addr[31:2], 2'b00};
            be_d    = be_calc;
            wdata_d = wdata_calc;
            size_d  = i_memSize;
            off_d   = i_addr[1:0];
            err_d   = 1'b0;
          end
        end
      end
      REQ: begin
        stall_c = 1'b1;
        if (bus.i_busAck) begin
          rdata_d = rd_aligned;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Timeout: the slave never answered, so return zero data.
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          req_d = 1'b1;
        end
      end
      DONE: begin
        err_c   = err_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'd0;
      off_q   <= 2'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      off_q   <= off_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Combinational flags are forced low during reset so the pipeline never
  // sees a stall or exception while the unit is being cleared.
  assign o_stall      = stall_c & ~reset;
  assign o_misaligned = misal_c & ~reset;
  assign o_busErr     = err_c & ~reset;
  assign o_readData   = rdata_q;

  assign bus.o_busReq   = req_q;
  assign bus.o_busWe    = we_q;
  assign bus.o_busAddr  = addr_q;
  assign bus.o_busBe    = be_q;
  assign bus.o_busWdata = wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_unit
// Directed bench for dmem_access_unit: store/load of each size, lane
// replication, misalignment rejection, timeout abort, ack-while-idle and
// reset in the middle of a bus cycle.
// ---------------------------------------------------------------------------
module tb_dmem_access_unit;
  logic        clk;
  logic        reset;
  logic        i_memRead;
  logic        i_memWrite;
  logic [1:0]  i_memSize;
  logic [31:0] i_addr;
  logic [31:0] i_writeData;
  logic        o_stall;
  logic [31:0] o_readData;
  logic        o_misaligned;
  logic        o_busErr;

  int checks   = 0;
  int failures = 0;
  int n_stall;
  int n_req;

  dmem_access_unit_if bus ();

  dmem_access_unit #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_memRead    (i_memRead),
    .i_memWrite   (i_memWrite),
    .i_memSize    (i_memSize),
    .i_addr       (i_addr),
    .i_writeData  (i_writeData),
    .o_stall      (o_stall),
    .o_readData   (o_readData),
    .o_misaligned (o_misaligned),
    .o_busErr     (o_busErr),
    .bus          (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Runs one access from its issue cycle until the stall drops, acking in
  // the ack_at-th stalled cycle (0 = never ack). Counts stalled cycles and
  // cycles with the bus request high.
  task automatic run_access(input int ack_at, output int stall_cycles, output int req_cycles);
    stall_cycles = 0;
    req_cycles   = 0;
    while (o_stall === 1'b1 && stall_cycles < 40) begin
      stall_cycles++;
      if (bus.o_busReq === 1'b1) req_cycles++;
      bus.i_busAck = (ack_at != 0 && stall_cycles == ack_at);
      tick();
    end
    bus.i_busAck = 1'b0;
    i_memRead    = 1'b0;
    i_memWrite   = 1'b0;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    i_memRead   = rd;
    i_memWrite  = wr;
    i_memSize   = sz;
    i_addr      = a;
    i_writeData = wd;
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    i_memRead      = 1'b1;
    i_memWrite     = 1'b0;
    i_memSize      = 2'b10;
    i_addr         = 32'h0000_0006;
    i_writeData    = 32'd0;
    bus.i_busAck   = 1'b0;
    bus.i_busRdata = 32'd0;

    // Reset: misaligned request pending, flags must stay low.
    tick();
    tick();
    check("rst_stall", {31'd0, o_stall}, 32'd0);
    check("rst_misal", {31'd0, o_misaligned}, 32'd0);
    check("rst_req", {31'd0, bus.o_busReq}, 32'd0);
    check("rst_addr", bus.o_busAddr, 32'd0);
    check("rst_be", {28'd0, bus.o_busBe}, 32'd0);
    check("rst_wdata", bus.o_busWdata, 32'd0);
    check("rst_rdata", o_readData, 32'd0);
    i_memRead = 1'b0;
    reset     = 1'b0;
    tick();
    check("idle_stall", {31'd0, o_stall}, 32'd0);

    // Store word, ack in first REQ cycle.
    issue(1'b0, 1'b1, 2'b10, 32'h0001_0008, 32'hDEAD_BEEF);
    check("sw_stall_issue", {31'd0, o_stall}, 32'd1);
    tick();
    check("sw_req", {31'd0, bus.o_busReq}, 32'd1);
    check("sw_addr", bus.o_busAddr, 32'h0001_0008);
    check("sw_be", {28'd0, bus.o_busBe}, 32'h0000_000F);
    check("sw_wdata", bus.o_busWdata, 32'hDEAD_BEEF);
    check("sw_we", {31'd0, bus.o_busWe}, 32'd1);
    run_access(1, n_stall, n_req);
    check("sw_stall_cycles", n_stall + 1, 32'd2);
    check("sw_done_req", {31'd0, bus.o_busReq}, 32'd0);
    check("sw_done_err", {31'd0, o_busErr}, 32'd0);
    tick();
    check("sw_idle_addr_held", bus.o_busAddr, 32'h0001_0008);

    // Load byte at offset 3, ack after three wait cycles.
    bus.i_busRdata = 32'h1122_3344;
    issue(1'b1, 1'b0, 2'b00, 32'h0000_0003, 32'd0);
    run_access(5, n_stall, n_req);
    check("lb_stall_cycles", n_stall, 32'd5);
    check("lb_be", {28'd0, bus.o_busBe}, 32'h0000_0008);
    check("lb_we", {31'd0, bus.o_busWe}, 32'd0);
    check("lb_rdata", o_readData, 32'h0000_0011);
    check("lb_done_stall", {31'd0, o_stall}, 32'd0);
    tick();

    // Store half at offset 2.
    issue(1'b0, 1'b1, 2'b01, 32'h0000_0002, 32'h0000_ABCD);
    tick();
    check("sh_be", {28'd0, bus.o_busBe}, 32'h0000_000C);
    check("sh_wdata", bus.o_busWdata, 32'hABCD_ABCD);
    check("sh_addr", bus.o_busAddr, 32'h0000_0000);
    run_access(1, n_stall, n_req);
    tick();

    // Read and write together: treated as a byte store.
    issue(1'b1, 1'b1, 2'b00, 32'h0000_0101, 32'h0000_005A);
    tick();
    check("rw_we", {31'd0, bus.o_busWe}, 32'd1);
    check("rw_be", {28'd0, bus.o_busBe}, 32'h0000_0002);
    check("rw_wdata", bus.o_busWdata, 32'h5A5A_5A5A);
    check("rw_addr", bus.o_busAddr, 32'h0000_0100);
    run_access(1, n_stall, n_req);
    tick();

    // Load half at offset 2; result must persist into the next IDLE.
    bus.i_busRdata = 32'hAABB_CCDD;
    issue(1'b1, 1'b0, 2'b01, 32'h0000_0006, 32'd0);
    run_access(2, n_stall, n_req);
    check("lh_rdata", o_readData, 32'h0000_AABB);
    check("lh_be", {28'd0, bus.o_busBe}, 32'h0000_000C);
    tick();
    check("lh_rdata_held", o_readData, 32'h0000_AABB);

    // Misaligned word load: rejected with no bus cycle.
    issue(1'b1, 1'b0, 2'b10, 32'h0000_0006, 32'd0);
    check("mis_flag", {31'd0, o_misaligned}, 32'd1);
    check("mis_stall", {31'd0, o_stall}, 32'd0);
    tick();
    check("mis_req", {31'd0, bus.o_busReq}, 32'd0);
    i_memRead = 1'b0;
    #1;
    check("mis_flag_clear", {31'd0, o_misaligned}, 32'd0);

    // Ack while idle is ignored.
    bus.i_busAck = 1'b1;
    tick();
    bus.i_busAck = 1'b0;
    check("idle_ack_req", {31'd0, bus.o_busReq}, 32'd0);
    check("idle_ack_stall", {31'd0, o_stall}, 32'd0);
    check("idle_ack_rdata", o_readData, 32'h0000_AABB);

    // Timeout: no ack ever.
    bus.i_busRdata = 32'hFFFF_FFFF;
    issue(1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'd0);
    run_access(0, n_stall, n_req);
    check("to_req_cycles", n_req, 32'd16);
    check("to_stall_cycles", n_stall, 32'd17);
    check("to_err", {31'd0, o_busErr}, 32'd1);
    check("to_rdata", o_readData, 32'd0);
    check("to_done_req", {31'd0, bus.o_busReq}, 32'd0);
    tick();
    check("to_err_clear", {31'd0, o_busErr}, 32'd0);

    // Reset during the second REQ cycle.
    issue(1'b1, 1'b0, 2'b10, 32'h0000_0200, 32'd0);
    tick();
    tick();
    check("rr_req_before", {31'd0, bus.o_busReq}, 32'd1);
    reset     = 1'b1;
    i_memRead = 1'b0;
    #1;
    check("rr_stall_in_reset", {31'd0, o_stall}, 32'd0);
    tick();
    reset = 1'b0;
    check("rr_req_after", {31'd0, bus.o_busReq}, 32'd0);
    check("rr_addr_after", bus.o_busAddr, 32'd0);
    bus.i_busAck = 1'b1;
    tick();
    bus.i_busAck = 1'b0;
    check("rr_late_ack_req", {31'd0, bus.o_busReq}, 32'd0);
    check("rr_late_ack_stall", {31'd0, o_stall}, 32'd0);
    check("rr_late_ack_err", {31'd0, o_busErr}, 32'd0);
    check("rr_rdata", o_readData, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
